// File: rtl/ptab_resolve_ctrl_if.sv
// Branch-resolve bus between the branch units, the resolve controller and the PTAB.
// Ports: req_* (per-BRU resolve requests), bru_* (PTAB verify port), pipe_flush/redirect_*/misp_cnt.
// The slave modport is the controller's view; the master modport is the BRU/PTAB side.
interface ptab_resolve_ctrl_if #(
  parameter int NUM_BRU    = 2,
  parameter int XLEN       = 32,
  parameter int PTAB_WIDTH = 4
);
  logic [NUM_BRU-1:0]            req_valid;
  logic [NUM_BRU-1:0]            req_ready;
  logic [NUM_BRU*PTAB_WIDTH-1:0] req_ptab_tag;
  logic [NUM_BRU-1:0]            req_dir;
  logic [NUM_BRU*XLEN-1:0]       req_target_pc;

  logic                          bru_valid;
  logic [PTAB_WIDTH-1:0]         bru_ptab_tag;
  logic                          bru_branch_dir;
  logic [XLEN-1:0]               bru_target_pc;
  logic                          bru_branch_misp;
  logic [XLEN-1:0]               bru_next_pc;

  logic                          pipe_flush;
  logic                          redirect_valid;
  logic [XLEN-1:0]               redirect_pc;
  logic [15:0]                   misp_cnt;

  modport slave (
    input  req_valid, req_ptab_tag, req_dir, req_target_pc,
    input  bru_branch_misp, bru_next_pc,
    output req_ready,
    output bru_valid, bru_ptab_tag, bru_branch_dir, bru_target_pc,
    output pipe_flush, redirect_valid, redirect_pc, misp_cnt
  );

  modport master (
    output req_valid, req_ptab_tag, req_dir, req_target_pc,
    output bru_branch_misp, bru_next_pc,
    input  req_ready,
    input  bru_valid, bru_ptab_tag, bru_branch_dir, bru_target_pc,
    input  pipe_flush, redirect_valid, redirect_pc, misp_cnt
  );
endinterface

// File: rtl/ptab_resolve_ctrl.sv
// Funnels NUM_BRU branch-resolve requests into the single PTAB verify port and turns a
// misprediction into a FLUSH_CYCLES-long pipe_flush plus a one-cycle fetch redirect.
// Ports: clk, rst (sync, active high), bus (slave modport of ptab_resolve_ctrl_if).
// Latency: request to bru_valid is 1 cycle. Backpressure: req_ready drops while a BRU's
// holding buffer is full or while flushing; it never depends on same-cycle inputs.
module ptab_resolve_ctrl #(
  parameter int NUM_BRU      = 2,
  parameter int XLEN         = 32,
  parameter int PTAB_WIDTH   = 4,
  parameter int FLUSH_CYCLES = 2
) (
  input  logic                  clk,
  input  logic                  rst,
  ptab_resolve_ctrl_if.slave    bus
);

  localparam int PTR_W = $clog2(NUM_BRU);
  localparam int CNT_W = $clog2(FLUSH_CYCLES + 1);

  typedef enum logic {RUN, FLUSH} state_t;

  state_t                 state;
  logic [CNT_W-1:0]       flush_cnt;
  logic [PTR_W-1:0]       ptr;

  logic [NUM_BRU-1:0]     buf_valid;
  logic [PTAB_WIDTH-1:0]  buf_tag [NUM_BRU];
  logic [NUM_BRU-1:0]     buf_dir;
  logic [XLEN-1:0]        buf_pc  [NUM_BRU];

  logic                   redirect_valid_q;
  logic [XLEN-1:0]        redirect_pc_q;
  logic [15:0]            misp_cnt_q;

  logic                   gnt_vld;
  logic [PTR_W-1:0]       gnt_idx;
  logic [PTR_W-1:0]       cand;
  logic                   issue;
  logic                   misp_event;
  logic [NUM_BRU-1:0]     accept;

  // Round-robin search starting just after the last winner, wrapping around.
  always_comb begin
    gnt_vld = 1'b0;
    gnt_idx = '0;
    cand    = '0;
    for (int i = 1; i <= NUM_BRU; i++) begin
      cand = PTR_W'((int'(ptr) + i) % NUM_BRU);
      if (!gnt_vld && buf_valid[cand]) begin
        gnt_vld = 1'b1;
        gnt_idx = cand;
      end
    end
  end

  assign issue      = gnt_vld && (state == RUN);
  // The PTAB result is only meaningful in a cycle we actually present a branch.
  assign misp_event = issue && bus.bru_branch_misp;

  assign bus.req_ready      = (state == RUN) ? ~buf_valid : '0;
  assign accept             = bus.req_valid & bus.req_ready;

  assign bus.bru_valid      = issue;
  assign bus.bru_ptab_tag   = issue ? buf_tag[gnt_idx] : '0;
  assign bus.bru_branch_dir = issue ? buf_dir[gnt_idx] : 1'b0;
  assign bus.bru_target_pc  = issue ? buf_pc[gnt_idx]  : '0;

  assign bus.pipe_flush     = (state == FLUSH);
  assign bus.redirect_valid = redirect_valid_q;
  assign bus.redirect_pc    = redirect_pc_q;
  assign bus.misp_cnt       = misp_cnt_q;

  // Control state: FSM, arbiter pointer, buffer occupancy and misprediction outputs.
  always_ff @(posedge clk) begin
    if (rst) begin
      state            <= RUN;
      flush_cnt        <= '0;
      ptr              <= PTR_W'(NUM_BRU - 1);
      buf_valid        <= '0;
      redirect_valid_q <= 1'b0;
      redirect_pc_q    <= '0;
      misp_cnt_q       <= '0;
    end else begin
      redirect_valid_q <= 1'b0;

      if (issue) begin
        ptr <= gnt_idx;
      end

      // A misprediction wipes every buffer, including one filled by a same-cycle accept.
      for (int k = 0; k < NUM_BRU; k++) begin
        if (misp_event) begin
          buf_valid[k] <= 1'b0;
        end else if (issue && (gnt_idx == PTR_W'(k))) begin
          buf_valid[k] <= 1'b0;
        end else if (accept[k]) begin
          buf_valid[k] <= 1'b1;
        end
      end

      case (state)
        RUN: begin
          if (misp_event) begin
            state            <= FLUSH;
            flush_cnt        <= CNT_W'(FLUSH_CYCLES - 1);
            redirect_valid_q <= 1'b1;
            redirect_pc_q    <= bus.bru_next_pc;
            misp_cnt_q       <= misp_cnt_q + 16'd1;
          end
        end
        FLUSH: begin
          if (flush_cnt == '0) begin
            state <= RUN;
          end else begin
            flush_cnt <= flush_cnt - CNT_W'(1);
          end
        end
        default: state <= RUN;
      endcase
    end
  end

  // Payload storage; only meaningful while the matching buf_valid bit is set.
  always_ff @(posedge clk) begin
    for (int k = 0; k < NUM_BRU; k++) begin
      if (accept[k]) begin
        buf_tag[k] <= bus.req_ptab_tag[k*PTAB_WIDTH +: PTAB_WIDTH];
        buf_dir[k] <= bus.req_dir[k];
        buf_pc[k]  <= bus.req_target_pc[k*XLEN +: XLEN];
      end
    end
  end

endmodule

// File: tb/tb_ptab_resolve_ctrl.sv
// Self-checking bench for ptab_resolve_ctrl (NUM_BRU=2, FLUSH_CYCLES=2).
// A per-cycle vector table drives requests and states the expected control outputs;
// accepted requests are queued per BRU and checked when they appear on the PTAB port.
module tb_ptab_resolve_ctrl;

  localparam int NUM_BRU = 2;
  localparam int XLEN    = 32;
  localparam int PW      = 4;
  localparam int NV      = 24;

  logic clk;
  logic rst;

  ptab_resolve_ctrl_if #(.NUM_BRU(NUM_BRU), .XLEN(XLEN), .PTAB_WIDTH(PW)) bus ();

  ptab_resolve_ctrl #(
    .NUM_BRU(NUM_BRU), .XLEN(XLEN), .PTAB_WIDTH(PW), .FLUSH_CYCLES(2)
  ) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus.slave)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [1:0]  rv;
    logic [3:0]  t0;
    logic [3:0]  t1;
    logic [1:0]  dir;
    logic        misp;
    logic [31:0] npc;
    logic [1:0]  e_rdy;
    logic        e_bv;
    logic        e_gnt;
    logic        e_fl;
    logic        e_rd;
    logic [15:0] e_cnt;
    logic [31:0] e_rpc;
  } vec_t;

  typedef struct packed {
    logic [3:0]  tag;
    logic        dir;
    logic [31:0] tgt;
  } exp_t;

  vec_t vt [NV];
  exp_t q0 [$];
  exp_t q1 [$];
  int   n_pass;
  int   n_total;

  function automatic vec_t mk(input logic [1:0] rv, input logic [3:0] t0, input logic [3:0] t1,
                              input logic [1:0] dir, input logic misp, input logic [31:0] npc,
                              input logic [1:0] e_rdy, input logic e_bv, input logic e_gnt,
                              input logic e_fl, input logic e_rd, input logic [15:0] e_cnt,
                              input logic [31:0] e_rpc);
    vec_t v;
    v.rv = rv; v.t0 = t0; v.t1 = t1; v.dir = dir; v.misp = misp; v.npc = npc;
    v.e_rdy = e_rdy; v.e_bv = e_bv; v.e_gnt = e_gnt; v.e_fl = e_fl; v.e_rd = e_rd;
    v.e_cnt = e_cnt; v.e_rpc = e_rpc;
    return v;
  endfunction

  function automatic logic [31:0] tgt(input int k, input logic [3:0] tag);
    return 32'h100 + (32'(k) << 12) + (32'(tag) << 4);
  endfunction

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", nm, act, exp);
  endtask

  task automatic drive(input logic [1:0] rv, input logic [3:0] t0, input logic [3:0] t1,
                       input logic [1:0] dir, input logic misp, input logic [31:0] npc);
    bus.req_valid       = rv;
    bus.req_ptab_tag    = {t1, t0};
    bus.req_dir         = dir;
    bus.req_target_pc   = {tgt(1, t1), tgt(0, t0)};
    bus.bru_branch_misp = misp;
    bus.bru_next_pc     = npc;
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  initial begin
    exp_t e;
    n_pass  = 0;
    n_total = 0;

    //          rv     t0  t1  dir   m  npc            rdy   bv g  fl rd cnt rpc
    vt[0]  = mk(2'b00, 0,  0,  2'b00,0, 32'h0,         2'b11,0, 0, 0, 0, 0, 32'h0);
    vt[1]  = mk(2'b01, 5,  0,  2'b01,0, 32'h0,         2'b11,0, 0, 0, 0, 0, 32'h0);
    vt[2]  = mk(2'b00, 0,  0,  2'b00,0, 32'h0,         2'b10,1, 0, 0, 0, 0, 32'h0);
    vt[3]  = mk(2'b00, 0,  0,  2'b00,0, 32'h0,         2'b11,0, 0, 0, 0, 0, 32'h0);
    vt[4]  = mk(2'b11, 1,  2,  2'b10,0, 32'h0,         2'b11,0, 0, 0, 0, 0, 32'h0);
    vt[5]  = mk(2'b11, 3,  4,  2'b01,0, 32'h0,         2'b00,1, 1, 0, 0, 0, 32'h0);
    vt[6]  = mk(2'b11, 3,  4,  2'b01,0, 32'h0,         2'b10,1, 0, 0, 0, 0, 32'h0);
    vt[7]  = mk(2'b11, 3,  6,  2'b11,0, 32'h0,         2'b01,1, 1, 0, 0, 0, 32'h0);
    vt[8]  = mk(2'b11, 7,  6,  2'b00,0, 32'h0,         2'b10,1, 0, 0, 0, 0, 32'h0);
    vt[9]  = mk(2'b00, 0,  0,  2'b00,0, 32'h0,         2'b01,1, 1, 0, 0, 0, 32'h0);
    vt[10] = mk(2'b00, 0,  0,  2'b00,1, 32'hdead,      2'b11,0, 0, 0, 0, 0, 32'h0);
    vt[11] = mk(2'b01, 9,  0,  2'b01,0, 32'h0,         2'b11,0, 0, 0, 0, 0, 32'h0);
    vt[12] = mk(2'b10, 0,  10, 2'b10,1, 32'h2000,      2'b10,1, 0, 0, 0, 0, 32'h0);
    vt[13] = mk(2'b11, 1,  1,  2'b00,0, 32'h0,         2'b00,0, 0, 1, 1, 1, 32'h2000);
    vt[14] = mk(2'b11, 1,  1,  2'b00,0, 32'h0,         2'b00,0, 0, 1, 0, 1, 32'h2000);
    vt[15] = mk(2'b00, 0,  0,  2'b00,0, 32'h0,         2'b11,0, 0, 0, 0, 1, 32'h2000);
    vt[16] = mk(2'b10, 0,  3,  2'b10,0, 32'h0,         2'b11,0, 0, 0, 0, 1, 32'h2000);
    vt[17] = mk(2'b00, 0,  0,  2'b00,0, 32'h0,         2'b01,1, 1, 0, 0, 1, 32'h2000);
    vt[18] = mk(2'b11, 8,  7,  2'b11,0, 32'h0,         2'b11,0, 0, 0, 0, 1, 32'h2000);
    vt[19] = mk(2'b00, 0,  0,  2'b00,1, 32'h3000,      2'b00,1, 0, 0, 0, 1, 32'h2000);
    vt[20] = mk(2'b00, 0,  0,  2'b00,0, 32'h0,         2'b00,0, 0, 1, 1, 2, 32'h3000);
    vt[21] = mk(2'b00, 0,  0,  2'b00,0, 32'h0,         2'b00,0, 0, 1, 0, 2, 32'h3000);
    vt[22] = mk(2'b00, 0,  0,  2'b00,0, 32'h0,         2'b11,0, 0, 0, 0, 2, 32'h3000);
    vt[23] = mk(2'b00, 0,  0,  2'b00,0, 32'h0,         2'b11,0, 0, 0, 0, 2, 32'h3000);

    rst = 1'b1;
    drive(2'b00, 0, 0, 2'b00, 1'b0, 32'h0);
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b0;

    for (int i = 0; i < NV; i++) begin
      drive(vt[i].rv, vt[i].t0, vt[i].t1, vt[i].dir, vt[i].misp, vt[i].npc);
      chk($sformatf("req_ready[c%0d]", i),      32'(bus.req_ready),      32'(vt[i].e_rdy));
      chk($sformatf("bru_valid[c%0d]", i),      32'(bus.bru_valid),      32'(vt[i].e_bv));
      chk($sformatf("pipe_flush[c%0d]", i),     32'(bus.pipe_flush),     32'(vt[i].e_fl));
      chk($sformatf("redirect_valid[c%0d]", i), 32'(bus.redirect_valid), 32'(vt[i].e_rd));
      chk($sformatf("misp_cnt[c%0d]", i),       32'(bus.misp_cnt),       32'(vt[i].e_cnt));
      chk($sformatf("redirect_pc[c%0d]", i),    bus.redirect_pc,         vt[i].e_rpc);

      if (bus.bru_valid) begin
        if ((vt[i].e_gnt ? q1.size() : q0.size()) == 0) begin
          chk($sformatf("issue_expected[c%0d]", i), 32'(1), 32'(0));
        end else begin
          e = vt[i].e_gnt ? q1.pop_front() : q0.pop_front();
          chk($sformatf("bru_ptab_tag[c%0d]", i),   32'(bus.bru_ptab_tag),   32'(e.tag));
          chk($sformatf("bru_branch_dir[c%0d]", i), 32'(bus.bru_branch_dir), 32'(e.dir));
          chk($sformatf("bru_target_pc[c%0d]", i),  bus.bru_target_pc,       e.tgt);
        end
      end

      if (vt[i].misp && vt[i].e_bv) begin
        q0.delete();
        q1.delete();
      end else begin
        if (vt[i].rv[0] && vt[i].e_rdy[0]) q0.push_back({vt[i].t0, vt[i].dir[0], tgt(0, vt[i].t0)});
        if (vt[i].rv[1] && vt[i].e_rdy[1]) q1.push_back({vt[i].t1, vt[i].dir[1], tgt(1, vt[i].t1)});
      end
      tick();
    end

    chk("q0_drained", 32'(q0.size()), 32'(0));
    chk("q1_drained", 32'(q1.size()), 32'(0));

    // Reset during FLUSH must end the flush at once and restore the arbiter pointer.
    drive(2'b01, 2, 0, 2'b00, 1'b0, 32'h0);
    tick();
    drive(2'b00, 0, 0, 2'b00, 1'b1, 32'h4000);
    chk("rf_issue", 32'(bus.bru_valid), 32'(1));
    tick();
    drive(2'b00, 0, 0, 2'b00, 1'b0, 32'h0);
    chk("rf_flush_m1",    32'(bus.pipe_flush),     32'(1));
    chk("rf_redir_m1",    32'(bus.redirect_valid), 32'(1));
    chk("rf_cnt_m1",      32'(bus.misp_cnt),       32'(3));
    rst = 1'b1;
    tick();
    rst = 1'b0;
    chk("rf_flush_m2",    32'(bus.pipe_flush),     32'(0));
    chk("rf_redir_m2",    32'(bus.redirect_valid), 32'(0));
    chk("rf_cnt_m2",      32'(bus.misp_cnt),       32'(0));
    chk("rf_rpc_m2",      bus.redirect_pc,         32'h0);
    chk("rf_ready_m2",    32'(bus.req_ready),      32'(3));
    chk("rf_bvalid_m2",   32'(bus.bru_valid),      32'(0));
    drive(2'b11, 1, 2, 2'b01, 1'b0, 32'h0);
    tick();
    drive(2'b00, 0, 0, 2'b00, 1'b0, 32'h0);
    chk("rf_first_valid", 32'(bus.bru_valid),      32'(1));
    chk("rf_first_tag",   32'(bus.bru_ptab_tag),   32'(1));
    chk("rf_first_pc",    bus.bru_target_pc,       tgt(0, 4'd1));
    tick();
    chk("rf_second_valid",32'(bus.bru_valid),      32'(1));
    chk("rf_second_tag",  32'(bus.bru_ptab_tag),   32'(2));
    chk("rf_second_dir",  32'(bus.bru_branch_dir), 32'(0));
    tick();
    chk("rf_idle_valid",  32'(bus.bru_valid),      32'(0));

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
